// File: rtl/cpu_run_ctrl.sv
// Run/step clock-enable controller and debug-view display scanner for the single-cycle core.
// Optional ebreak trap in free-run: define EBREAK_TRAP_EN.
//
// state | meaning
// IDLE  | core halted, waiting for run level or step edge
// RUN   | free-run, one cpu_ce pulse per tick
// STEP  | single cpu_ce pulse just issued, returning to IDLE
// TRAP  | halted on ebreak in free-run, waits for run to drop
module cpu_run_ctrl #(
  parameter int DIV_W = 25,
  parameter int RF_N  = 32,
  parameter int DM_N  = 16
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_slow_sel,
  input  logic        i_run,
  input  logic        i_step,
  input  logic [3:0]  i_view_sel,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rf_rdata,
  input  logic [7:0]  i_dm_rdata,
  input  logic [31:0] i_alu_a,
  input  logic [31:0] i_alu_b,
  input  logic [31:0] i_alu_c,
  input  logic        i_alu_zero,
  output logic        o_cpu_ce,
  output logic [4:0]  o_rf_raddr,
  output logic [5:0]  o_dm_raddr,
  output logic [1:0]  o_alu_sel,
  output logic [31:0] o_disp_data,
  output logic [1:0]  o_state
);

  localparam int          PW      = DIV_W + 2;
  localparam logic [4:0]  RF_LAST = 5'(RF_N - 1);
  localparam logic [5:0]  DM_LAST = 6'(DM_N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_TRAP = 2'b11
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_cpu_ce;
  logic        w_cpu_ce_nxt;
  logic [PW-1:0] r_pcnt;
  logic        r_step_q;
  logic        w_tick;
  logic        w_step_rise;
  logic        w_is_ebreak;
  logic [4:0]  r_rf_raddr;
  logic [5:0]  r_dm_raddr;
  logic [1:0]  r_alu_sel;
  logic [31:0] r_disp_data;
  logic [31:0] w_alu_word;

  assign w_tick      = i_slow_sel ? (&r_pcnt) : (&r_pcnt[DIV_W-1:0]);
  assign w_step_rise = i_step & ~r_step_q;

`ifdef EBREAK_TRAP_EN
  assign w_is_ebreak = (i_instr == 32'h0010_0073);
`else
  assign w_is_ebreak = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_pcnt   <= '0;
      r_step_q <= 1'b0;
      r_state  <= S_IDLE;
      r_cpu_ce <= 1'b0;
    end else begin
      r_pcnt   <= r_pcnt + 1'b1;
      r_step_q <= i_step;
      r_state  <= w_state_nxt;
      r_cpu_ce <= w_cpu_ce_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cpu_ce_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        // run has priority over a coincident step edge
        if (i_run) begin
          w_state_nxt = S_RUN;
        end else if (w_step_rise) begin
          w_state_nxt  = S_STEP;
          w_cpu_ce_nxt = 1'b1;
        end
      end
      S_STEP: w_state_nxt = S_IDLE;
      S_RUN: begin
        if (!i_run) begin
          w_state_nxt = S_IDLE;
        end else if (w_tick) begin
          if (w_is_ebreak) w_state_nxt = S_TRAP;
          else             w_cpu_ce_nxt = 1'b1;
        end
      end
      S_TRAP: if (!i_run) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_alu_word = i_alu_a;
    case (r_alu_sel)
      2'd0:    w_alu_word = i_alu_a;
      2'd1:    w_alu_word = i_alu_b;
      2'd2:    w_alu_word = i_alu_c;
      default: w_alu_word = {31'b0, i_alu_zero};
    endcase
  end

  // Each view captures data for the current address, then advances that view's address only.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_rf_raddr  <= '0;
      r_dm_raddr  <= '0;
      r_alu_sel   <= '0;
      r_disp_data <= '0;
    end else begin
      case (i_view_sel)
        4'b0100: if (w_tick) begin
          r_disp_data <= i_rf_rdata;
          r_rf_raddr  <= (r_rf_raddr == RF_LAST) ? 5'd0 : r_rf_raddr + 5'd1;
        end
        4'b0001: if (w_tick) begin
          r_disp_data <= {24'b0, i_dm_rdata};
          r_dm_raddr  <= (r_dm_raddr == DM_LAST) ? 6'd0 : r_dm_raddr + 6'd1;
        end
        4'b0010: if (w_tick) begin
          r_disp_data <= w_alu_word;
          r_alu_sel   <= r_alu_sel + 2'd1;
        end
        default: r_disp_data <= i_instr;
      endcase
    end
  end

  assign o_cpu_ce    = r_cpu_ce;
  assign o_state     = r_state;
  assign o_rf_raddr  = r_rf_raddr;
  assign o_dm_raddr  = r_dm_raddr;
  assign o_alu_sel   = r_alu_sel;
  assign o_disp_data = r_disp_data;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl (DIV_W=2): expected cpu_ce pulse cycles and scan records are queued
// by the stimulus thread and drained by monitors on each DUT pulse / scan-address change.
module tb_cpu_run_ctrl;

  logic        clk;
  logic        rstn;
  logic        slow_sel;
  logic        run;
  logic        step;
  logic [3:0]  view_sel;
  logic [31:0] instr;
  logic [31:0] rf_rdata;
  logic [7:0]  dm_rdata;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_c;
  logic        alu_zero;
  logic        o_cpu_ce;
  logic [4:0]  o_rf_raddr;
  logic [5:0]  o_dm_raddr;
  logic [1:0]  o_alu_sel;
  logic [31:0] o_disp_data;
  logic [1:0]  o_state;

  cpu_run_ctrl #(.DIV_W(2), .RF_N(32), .DM_N(16)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_slow_sel(slow_sel), .i_run(run), .i_step(step),
    .i_view_sel(view_sel), .i_instr(instr), .i_rf_rdata(rf_rdata), .i_dm_rdata(dm_rdata),
    .i_alu_a(alu_a), .i_alu_b(alu_b), .i_alu_c(alu_c), .i_alu_zero(alu_zero),
    .o_cpu_ce(o_cpu_ce), .o_rf_raddr(o_rf_raddr), .o_dm_raddr(o_dm_raddr),
    .o_alu_sel(o_alu_sel), .o_disp_data(o_disp_data), .o_state(o_state)
  );

  // RF holds x[i]=i; DM byte at address a holds 0xA0+a
  assign rf_rdata = {27'b0, o_rf_raddr};
  assign dm_rdata = 8'hA0 + {2'b0, o_dm_raddr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  rf;
    logic [5:0]  dm;
    logic [1:0]  alu;
  } scan_t;

  int          checks;
  int          failures;
  logic [31:0] cyc;
  logic [31:0] ce_q[$];
  scan_t       scan_q[$];
  logic [4:0]  p_rf;
  logic [5:0]  p_dm;
  logic [1:0]  p_alu;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_scan(input logic [31:0] d, input logic [4:0] rf, input logic [5:0] dm,
                           input logic [1:0] alu);
    scan_t e;
    e.d = d; e.rf = rf; e.dm = dm; e.alu = alu;
    scan_q.push_back(e);
  endtask

  task automatic at(input logic [31:0] n);
    do @(negedge clk); while (cyc < n);
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 32'd0;
    else       cyc <= cyc + 32'd1;
  end

  always @(negedge clk) begin
    if (rstn && o_cpu_ce) begin
      if (ce_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL ce_unexpected: pulse at cycle %0d, expected none", cyc);
      end else begin
        chk("ce_cycle", cyc, ce_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && (o_rf_raddr != p_rf || o_dm_raddr != p_dm || o_alu_sel != p_alu)) begin
      if (scan_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scan_unexpected: address change at cycle %0d, expected none", cyc);
      end else begin
        scan_t e;
        e = scan_q.pop_front();
        chk("scan_disp", o_disp_data, e.d);
        chk("scan_addr", {19'b0, o_rf_raddr, o_dm_raddr, o_alu_sel}, {19'b0, e.rf, e.dm, e.alu});
      end
    end
    p_rf  = o_rf_raddr;
    p_dm  = o_dm_raddr;
    p_alu = o_alu_sel;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] alu_exp [5];
    checks = 0; failures = 0;
    p_rf = '0; p_dm = '0; p_alu = '0;
    rstn = 1'b0; slow_sel = 1'b0; run = 1'b1; step = 1'b0;
    view_sel = 4'b1000; instr = 32'h0000_0013;
    alu_a = 32'd5; alu_b = 32'd7; alu_c = 32'd12; alu_zero = 1'b0;

    @(negedge clk);
    chk("rst_ce", {31'b0, o_cpu_ce}, 32'd0);
    chk("rst_state", {30'b0, o_state}, 32'd0);
    chk("rst_addr", {19'b0, o_rf_raddr, o_dm_raddr, o_alu_sel}, 32'd0);
    chk("rst_disp", o_disp_data, 32'd0);
    #12 rstn = 1'b1;

    // fast run: pulse after each edge where pcnt[1:0]==3
    for (int i = 4; i <= 20; i += 4) ce_q.push_back(32'(i));
    at(2);
    chk("im_disp", o_disp_data, 32'h0000_0013);
    at(3);
    chk("run_state", {30'b0, o_state}, 32'd1);
    at(21); #1 run = 1'b0;
    at(30);
    chk("run_drop_idle", {30'b0, o_state}, 32'd0);
    #1 slow_sel = 1'b1; run = 1'b1;
    ce_q.push_back(32'd32); ce_q.push_back(32'd48); ce_q.push_back(32'd64);
    at(65); #1 run = 1'b0; slow_sel = 1'b0;

    // step held high: one pulse per rise
    at(70); #1 step = 1'b1; ce_q.push_back(32'd71);
    at(71);
    chk("step_state", {30'b0, o_state}, 32'd2);
    at(72);
    chk("step_back_idle", {30'b0, o_state}, 32'd0);
    at(80); #1 step = 1'b0;
    at(85); #1 step = 1'b1; ce_q.push_back(32'd86);
    at(88); #1 step = 1'b0;

    // run and step rise together: run wins, no step pulse
    at(90); #1 run = 1'b1; step = 1'b1;
    ce_q.push_back(32'd92); ce_q.push_back(32'd96);
    at(91);
    chk("run_wins_state", {30'b0, o_state}, 32'd1);
    chk("run_wins_ce", {31'b0, o_cpu_ce}, 32'd0);
    at(97); #1 run = 1'b0; step = 1'b0;

    // reset asserted while a step pulse is high
    at(100); #1 step = 1'b1; ce_q.push_back(32'd101);
    at(101);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_ce", {31'b0, o_cpu_ce}, 32'd0);
    chk("async_rst_state", {30'b0, o_state}, 32'd0);
    step = 1'b0; view_sel = 4'b0100;
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;

    // RF scan: 0..31 then wrap to 0
    for (int i = 0; i < 33; i++) push_scan(32'(i % 32), 5'((i + 1) % 32), 6'd0, 2'd0);
    at(133); #1 view_sel = 4'b0010;
    alu_exp[0] = 32'd5; alu_exp[1] = 32'd7; alu_exp[2] = 32'd12; alu_exp[3] = 32'd0; alu_exp[4] = 32'd5;
    for (int i = 0; i < 5; i++) push_scan(alu_exp[i], 5'd1, 6'd0, 2'((i + 1) % 4));
    at(153); #1 view_sel = 4'b0001;
    for (int j = 0; j < 17; j++) push_scan(32'(160 + j % 16), 5'd1, 6'((j + 1) % 16), 2'd1);

    // non-one-hot view follows instr every clk, addresses hold
    at(221); #1 view_sel = 4'b0110; instr = 32'h1234_5678;
    at(222);
    chk("bad_view_disp0", o_disp_data, 32'h1234_5678);
    #1 instr = 32'hCAFE_F00D;
    at(223);
    chk("bad_view_disp1", o_disp_data, 32'hCAFE_F00D);
    #1 view_sel = 4'b0100;
    push_scan(32'd1, 5'd2, 6'd1, 2'd1);

    // ebreak in free-run
    at(226); #1 view_sel = 4'b1000; instr = 32'h0010_0073; run = 1'b1;
`ifndef EBREAK_TRAP_EN
    ce_q.push_back(32'd228); ce_q.push_back(32'd232);
`endif
    at(230);
`ifdef EBREAK_TRAP_EN
    chk("trap_state", {30'b0, o_state}, 32'd3);
`else
    chk("ebreak_run_state", {30'b0, o_state}, 32'd1);
`endif
    chk("ebreak_disp", o_disp_data, 32'h0010_0073);
    at(233); #1 run = 1'b0;
    at(235);
    chk("ebreak_exit_idle", {30'b0, o_state}, 32'd0);
    #1 step = 1'b1; ce_q.push_back(32'd236);
    at(240); #1 step = 1'b0;

    at(245);
    chk("ce_q_drained", 32'(ce_q.size()), 32'd0);
    chk("scan_q_drained", 32'(scan_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
